// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined core front end: fetch states,
// default widths and the instruction constants the sequencer cares about.
package cpu_pkg;

    localparam int PC_W = 16;

    localparam logic [6:0]  HALT_OP = 7'h7F;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        FILL   = 3'd1,
        RUN    = 3'd2,
        STALL  = 3'd3,
        REFILL = 3'd4,
        HALT   = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Once it reaches all-ones it stays there until cleared.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end sequencer: drives pc load, instruction-memory read and IF/ID
// enable/flush through start-up fill, stalls, redirects and halt.
module fetch_ctrl #(
    parameter int         PC_W    = cpu_pkg::PC_W,
    parameter logic [6:0] HALT_OP = cpu_pkg::HALT_OP,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic [6:0]       id_opcode,
    output logic             pc_en,
    output logic [PC_W-1:0]  pc_next,
    output logic             imem_rden,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] bubble_cnt
);

    import cpu_pkg::*;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [PC_W-1:0] r_pc_q;
    logic [PC_W-1:0] r_redir_next;
    logic            r_id_valid;

    logic            w_pc_en;
    logic [PC_W-1:0] w_pc_next;
    logic            w_imem_rden;
    logic            w_ifid_en;
    logic            w_ifid_flush;
    logic            w_redir_load;
    logic            w_bub_inc;
    logic            w_bub_clear;
    logic            w_halt_hit;

    assign w_halt_hit = r_id_valid && (id_opcode == HALT_OP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority inside the active states: redirect > halt > stall > run.
    // A stall in FILL/REFILL freezes that one-cycle state in place.
    always_comb begin
        w_state_next = r_state;
        w_pc_en      = 1'b0;
        w_pc_next    = r_pc_q + PC_ONE;
        w_imem_rden  = 1'b0;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;
        w_redir_load = 1'b0;
        w_bub_inc    = 1'b0;
        case (r_state)
            RESET: begin
                w_pc_next    = '0;
                w_ifid_en    = 1'b1;
                w_ifid_flush = 1'b1;
                w_state_next = FILL;
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                if (redirect_valid) begin
                    w_pc_en      = 1'b1;
                    w_pc_next    = redirect_pc;
                    w_imem_rden  = 1'b1;
                    w_ifid_en    = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_redir_load = 1'b1;
                    w_bub_inc    = !r_id_valid && (r_state != FILL);
                    w_state_next = REFILL;
                end else if (w_halt_hit) begin
                    w_state_next = HALT;
                end else if (stall_req) begin
                    w_state_next = ((r_state == FILL) || (r_state == REFILL)) ? r_state : STALL;
                end else begin
                    w_pc_en      = 1'b1;
                    w_imem_rden  = 1'b1;
                    w_ifid_en    = 1'b1;
                    w_bub_inc    = !r_id_valid && (r_state != FILL);
                    w_state_next = RUN;
                    if (r_state == FILL) begin
                        w_ifid_flush = 1'b1;
                    end else if (r_state == REFILL) begin
                        w_ifid_flush = 1'b1;
                        w_pc_next    = r_redir_next;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc_q       <= '0;
            r_redir_next <= '0;
            r_id_valid   <= 1'b0;
        end else begin
            if (w_pc_en) begin
                r_pc_q <= w_pc_next;
            end
            if (w_redir_load) begin
                r_redir_next <= redirect_pc + PC_ONE;
            end
            if (w_ifid_en) begin
                r_id_valid <= !w_ifid_flush;
            end
        end
    end

    assign w_bub_clear = !rst;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .clear (w_bub_clear),
        .inc   (w_bub_inc),
        .count (bubble_cnt)
    );

    assign pc_en      = w_pc_en;
    assign pc_next    = w_pc_next;
    assign imem_rden  = w_imem_rden;
    assign ifid_en    = w_ifid_en;
    assign ifid_flush = w_ifid_flush;
    assign id_valid   = r_id_valid;
    assign halted     = (r_state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset/fill, stall, redirect, stall+redirect
// conflict, pc wrap and halt, each cycle checked against hand-derived values.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_req;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [6:0]  id_opcode;
    logic        pc_en;
    logic [15:0] pc_next;
    logic        imem_rden;
    logic        ifid_en;
    logic        ifid_flush;
    logic        id_valid;
    logic        halted;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_req      (stall_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_opcode      (id_opcode),
        .pc_en          (pc_en),
        .pc_next        (pc_next),
        .imem_rden      (imem_rden),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .id_valid       (id_valid),
        .halted         (halted),
        .bubble_cnt     (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are checked 1 unit later.
    task automatic applyStimulus(input logic s, input logic rv, input logic [15:0] rpc, input logic [6:0] op);
        @(posedge clk);
        #1;
        stall_req      = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_opcode      = op;
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        stall_req      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_opcode      = '0;
        $display("[TB] start");

        applyStimulus(0, 0, 16'h0, 7'h0);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("rst_pc_en", pc_en, 0);
        checkOutput("rst_pc_next", pc_next, 0);
        checkOutput("rst_rden", imem_rden, 0);
        checkOutput("rst_ifid_en", ifid_en, 1);
        checkOutput("rst_flush", ifid_flush, 1);
        checkOutput("rst_id_valid", id_valid, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_bubble", bubble_cnt, 0);

        rst = 1'b1;
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("fill_pc_en", pc_en, 1);
        checkOutput("fill_pc_next", pc_next, 16'h1);
        checkOutput("fill_rden", imem_rden, 1);
        checkOutput("fill_flush", ifid_flush, 1);
        checkOutput("fill_id_valid", id_valid, 0);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("run1_pc_next", pc_next, 16'h2);
        checkOutput("run1_flush", ifid_flush, 0);
        checkOutput("run1_id_valid", id_valid, 0);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("run2_pc_next", pc_next, 16'h3);
        checkOutput("run2_id_valid", id_valid, 1);
        checkOutput("run2_bubble", bubble_cnt, 1);
        applyStimulus(0, 0, 16'h0, 7'h0);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("run4_pc_next", pc_next, 16'h5);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 16'h0, 7'h0);
            checkOutput("stall_pc_en", pc_en, 0);
            checkOutput("stall_rden", imem_rden, 0);
            checkOutput("stall_ifid_en", ifid_en, 0);
            checkOutput("stall_pc_held", pc_next, 16'h6);
            checkOutput("stall_id_valid", id_valid, 1);
        end
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("unstall_pc_en", pc_en, 1);
        checkOutput("unstall_pc_next", pc_next, 16'h6);
        checkOutput("unstall_bubble", bubble_cnt, 1);
        applyStimulus(0, 0, 16'h0, 7'h0);
        applyStimulus(0, 0, 16'h0, 7'h0);

        applyStimulus(0, 1, 16'h0040, 7'h0);
        checkOutput("redir_pc_en", pc_en, 1);
        checkOutput("redir_pc_next", pc_next, 16'h0040);
        checkOutput("redir_rden", imem_rden, 1);
        checkOutput("redir_flush", ifid_flush, 1);
        checkOutput("redir_ifid_en", ifid_en, 1);
        applyStimulus(0, 0, 16'h1234, 7'h0);
        checkOutput("refill_pc_next", pc_next, 16'h0041);
        checkOutput("refill_flush", ifid_flush, 1);
        checkOutput("refill_id_valid", id_valid, 0);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("redir2_pc_next", pc_next, 16'h0042);
        checkOutput("redir2_id_valid", id_valid, 0);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("redir3_id_valid", id_valid, 1);
        checkOutput("redir3_bubble", bubble_cnt, 3);

        applyStimulus(1, 1, 16'h0080, 7'h0);
        checkOutput("conf_pc_en", pc_en, 1);
        checkOutput("conf_pc_next", pc_next, 16'h0080);
        checkOutput("conf_flush", ifid_flush, 1);
        checkOutput("conf_rden", imem_rden, 1);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("conf_refill_pc", pc_next, 16'h0081);
        checkOutput("conf_refill_idv", id_valid, 0);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("conf_run_pc", pc_next, 16'h0082);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("conf_id_valid", id_valid, 1);
        checkOutput("conf_bubble", bubble_cnt, 5);

        applyStimulus(0, 1, 16'hFFFE, 7'h0);
        checkOutput("wrap0", pc_next, 16'hFFFE);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("wrap1", pc_next, 16'hFFFF);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("wrap2", pc_next, 16'h0000);
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("wrap3", pc_next, 16'h0001);
        checkOutput("wrap_bubble", bubble_cnt, 7);

        applyStimulus(0, 0, 16'h0, 7'h7F);
        checkOutput("halt_seen_pc_en", pc_en, 0);
        checkOutput("halt_seen_halted", halted, 0);
        applyStimulus(0, 0, 16'h0, 7'h7F);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_pc_en", pc_en, 0);
        checkOutput("halt_rden", imem_rden, 0);
        checkOutput("halt_ifid_en", ifid_en, 0);
        applyStimulus(0, 1, 16'h0010, 7'h7F);
        checkOutput("halt_redir_pc_en", pc_en, 0);
        checkOutput("halt_redir_rden", imem_rden, 0);
        applyStimulus(0, 0, 16'h0, 7'h7F);
        checkOutput("halt_stays", halted, 1);
        checkOutput("halt_no_refill", ifid_flush, 0);

        rst = 1'b0;
        applyStimulus(0, 0, 16'h0, 7'h0);
        checkOutput("rst2_halted", halted, 0);
        checkOutput("rst2_pc_en", pc_en, 0);
        checkOutput("rst2_pc_next", pc_next, 0);
        checkOutput("rst2_flush", ifid_flush, 1);
        checkOutput("rst2_id_valid", id_valid, 0);
        checkOutput("rst2_bubble", bubble_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
